demux_2way_loader: RTL and testbench

Switch-driven 1-to-2 demultiplexer/loader for the iCE40HX1K board: the user composes a 4-bit value on the LEDs, selects destination A or B, and commits it into that destination register. It is the write-side counterpart of the 2:1 LED mux that reads two 4-bit sources. Its o_Dest_A / o_Dest_B outputs feed the A/B operands of the mux and other display blocks.

---
 rtl/demux_2way_pkg.sv | 21 ++
 rtl/demux_2way_loader_debounce.sv | 48 ++++
 rtl/demux_2way_loader.sv | 91 +++++++++
 tb/tb_demux_2way_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/demux_2way_pkg.sv
// Shared definitions for the switch-driven 2-way loader: display modes and nibble width.
package demux_2way_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        MODE_ENTRY  = 2'd0,
        MODE_VIEW_A = 2'd1,
        MODE_VIEW_B = 2'd2
    } mode_t;

    // The unused code 2'd3 falls into the default arm and recovers to ENTRY.
    function automatic mode_t next_mode(input mode_t mode);
        case (mode)
            MODE_ENTRY:  return MODE_VIEW_A;
            MODE_VIEW_A: return MODE_VIEW_B;
            default:     return MODE_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/demux_2way_loader_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, debounced level
// and a single-cycle press pulse on each debounced rising level.
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_prev;
    logic [CNT_W-1:0] count;

    // NOTE: every register here uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            o_Level    <= 1'b0;
            level_prev <= 1'b0;
            count      <= '0;
        end else begin
            sync_q1    <= i_Switch;
            sync_q2    <= sync_q1;
            level_prev <= o_Level;
            if (sync_q2 != o_Level) begin
                if (count == CNT_LAST) begin
                    o_Level <= sync_q2;
                    count   <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

    assign o_Press = o_Level & ~level_prev;

endmodule

// File: rtl/demux_2way_loader.sv
// Four-button loader: compose a nibble, pick destination A/B, commit it, and
// view entry/A/B on the LEDs.
module demux_2way_loader
    import demux_2way_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int WIDTH          = NIBBLE_W
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Switch_1,
    input  logic             i_Switch_2,
    input  logic             i_Switch_3,
    input  logic             i_Switch_4,
    output logic             o_LED_1,
    output logic             o_LED_2,
    output logic             o_LED_3,
    output logic             o_LED_4,
    output logic [WIDTH-1:0] o_Dest_A,
    output logic [WIDTH-1:0] o_Dest_B,
    output logic             o_Load_A,
    output logic             o_Load_B,
    output logic             o_Sel
);

    logic [3:0]       raw_switch;
    logic [3:0]       press;
    logic [3:0]       level_unused;
    logic [WIDTH-1:0] entry;
    logic [WIDTH-1:0] display;
    mode_t            mode;

    assign raw_switch = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // Only the press pulses drive state; debounced levels stay internal.
    for (genvar i = 0; i < 4; i++) begin : g_switch
        switch_debounce #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_switch_debounce (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Switch (raw_switch[i]),
            .o_Level  (level_unused[i]),
            .o_Press  (press[i])
        );
    end

    // Simultaneous presses commit the pre-edge entry and select values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            entry    <= '0;
            o_Sel    <= 1'b0;
            o_Dest_A <= '0;
            o_Dest_B <= '0;
            o_Load_A <= 1'b0;
            o_Load_B <= 1'b0;
            mode     <= MODE_ENTRY;
        end else begin
            o_Load_A <= 1'b0;
            o_Load_B <= 1'b0;
            if (press[0]) entry <= entry + WIDTH'(1);
            if (press[1]) o_Sel <= ~o_Sel;
            if (press[2]) begin
                if (!o_Sel) begin
                    o_Dest_A <= entry;
                    o_Load_A <= 1'b1;
                end else begin
                    o_Dest_B <= entry;
                    o_Load_B <= 1'b1;
                end
            end
            if (press[3]) mode <= next_mode(mode);
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        display = entry;
        case (mode)
            MODE_VIEW_A: display = o_Dest_A;
            MODE_VIEW_B: display = o_Dest_B;
            default:     display = entry;
        endcase
    end

    assign o_LED_1 = display[0];
    assign o_LED_2 = display[1];
    assign o_LED_3 = display[2];
    assign o_LED_4 = display[3];

endmodule

// File: tb/tb_demux_2way_loader.sv
// Directed bench for demux_2way_loader with DEBOUNCE_LIMIT = 4; commit strobes
// are checked by a scoreboard monitor, state and LEDs by direct checks.
module tb_demux_2way_loader;

    localparam int LIMIT = 4;

    typedef struct {
        logic       is_b;
        logic [3:0] a;
        logic [3:0] b;
    } load_t;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       led_1, led_2, led_3, led_4;
    logic [3:0] dest_a, dest_b;
    logic       load_a, load_b, sel;
    logic [3:0] led;

    int    vectors;
    int    miscompares;
    load_t exp_q[$];

    demux_2way_loader #(
        .DEBOUNCE_LIMIT(LIMIT),
        .WIDTH(4)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch_1 (sw[0]),
        .i_Switch_2 (sw[1]),
        .i_Switch_3 (sw[2]),
        .i_Switch_4 (sw[3]),
        .o_LED_1    (led_1),
        .o_LED_2    (led_2),
        .o_LED_3    (led_3),
        .o_LED_4    (led_4),
        .o_Dest_A   (dest_a),
        .o_Dest_B   (dest_b),
        .o_Load_A   (load_a),
        .o_Load_B   (load_b),
        .o_Sel      (sel)
    );

    assign led = {led_4, led_3, led_2, led_1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued commit.
    always @(negedge clk) begin
        if (!rst && (load_a || load_b)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_load: got load_a=%b load_b=%b, expected none (t=%0t)",
                         load_a, load_b, $time);
            end else begin
                load_t e;
                e = exp_q.pop_front();
                check("load_strobes", {6'd0, load_b, load_a}, e.is_b ? 8'd2 : 8'd1);
                check("load_dest_a", {4'd0, dest_a}, {4'd0, e.a});
                check("load_dest_b", {4'd0, dest_b}, {4'd0, e.b});
            end
        end
    end

    task automatic press(input logic [3:0] mask);
        @(negedge clk) sw = mask;
        repeat (8) @(negedge clk);
        sw = 4'b0000;
        repeat (8) @(negedge clk);
    endtask

    task automatic press_n(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        sw          = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_led", {4'd0, led}, 8'd0);
        check("rst_dest_a", {4'd0, dest_a}, 8'd0);
        check("rst_dest_b", {4'd0, dest_b}, 8'd0);
        check("rst_sel", {7'd0, sel}, 8'd0);
        check("rst_loads", {6'd0, load_b, load_a}, 8'd0);

        // Three increments, no strobes expected
        press_n(4'b0001, 3);
        check("entry_3", {4'd0, led}, 8'b0000_0011);

        // Entry 5 committed to A, then to B after a select toggle
        press_n(4'b0001, 2);
        check("entry_5", {4'd0, led}, 8'b0000_0101);
        exp_q.push_back('{is_b: 1'b0, a: 4'b0101, b: 4'b0000});
        press(4'b0100);
        check("commit_a", {4'd0, dest_a}, 8'b0000_0101);
        check("commit_a_b_unchanged", {4'd0, dest_b}, 8'd0);
        press(4'b0010);
        check("sel_b", {7'd0, sel}, 8'd1);
        exp_q.push_back('{is_b: 1'b1, a: 4'b0101, b: 4'b0101});
        press(4'b0100);
        check("commit_b", {4'd0, dest_b}, 8'b0000_0101);

        // Wrap: 5 -> 15, then 16 presses wrap through 0 back to 15
        press_n(4'b0001, 10);
        check("entry_15", {4'd0, led}, 8'd15);
        press(4'b0001);
        check("wrap_to_0", {4'd0, led}, 8'd0);
        press_n(4'b0001, 15);
        check("wrap_back_15", {4'd0, led}, 8'd15);

        // Bounce every 2 cycles for 40 cycles, then stable: one increment at N+6
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) sw[0] = (i % 2 == 0);
            @(negedge clk);
        end
        @(negedge clk) sw[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("bounce_before_edge", {4'd0, led}, 8'd15);
        @(negedge clk);
        check("bounce_at_edge", {4'd0, led}, 8'd0);
        repeat (4) @(negedge clk);
        sw[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_single_inc", {4'd0, led}, 8'd0);

        // Set B = 1010 (sel is 1), entry = 0011, then cycle the display
        press_n(4'b0001, 10);
        exp_q.push_back('{is_b: 1'b1, a: 4'b0101, b: 4'b1010});
        press(4'b0100);
        press_n(4'b0001, 9);
        press(4'b1000);
        check("view_a", {4'd0, led}, 8'b0000_0101);
        press(4'b1000);
        check("view_b", {4'd0, led}, 8'b0000_1010);
        press(4'b1000);
        check("view_entry", {4'd0, led}, 8'b0000_0011);
        press(4'b1000);
        check("view_a_again", {4'd0, led}, 8'b0000_0101);
        press_n(4'b1000, 2);
        check("back_to_entry", {4'd0, led}, 8'b0000_0011);

        // Simultaneous increment/toggle/commit with entry 7, sel 0
        press_n(4'b0001, 4);
        press(4'b0010);
        check("pre_sim_sel", {7'd0, sel}, 8'd0);
        exp_q.push_back('{is_b: 1'b0, a: 4'b0111, b: 4'b1010});
        press(4'b0111);
        check("sim_dest_a", {4'd0, dest_a}, 8'b0000_0111);
        check("sim_entry", {4'd0, led}, 8'b0000_1000);
        check("sim_sel", {7'd0, sel}, 8'd1);
        check("sim_dest_b", {4'd0, dest_b}, 8'b0000_1010);

        // Reset mid-debounce of Switch_3; held switch commits 0 to A at N+6
        @(negedge clk) sw[2] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_led", {4'd0, led}, 8'd0);
        check("midrst_dests", {dest_b, dest_a}, 8'd0);
        check("midrst_sel_loads", {5'd0, sel, load_b, load_a}, 8'd0);
        exp_q.push_back('{is_b: 1'b0, a: 4'b0000, b: 4'b0000});
        repeat (6) @(negedge clk);
        check("held_no_load_yet", {6'd0, load_b, load_a}, 8'd0);
        @(negedge clk);
        check("held_load_a", {6'd0, load_b, load_a}, 8'd1);
        sw[2] = 1'b0;
        repeat (10) @(negedge clk);
        check("held_load_a_done", {6'd0, load_b, load_a}, 8'd0);

        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
